// File: rtl/trb_pkg.sv
// Shared constants and FSM state type for the turbo output byte-to-line packer.
package trb_pkg;

  localparam int unsigned DEF_LINE_W       = 512;
  localparam int unsigned DEF_NUM_LINE_BUF = 4;
  localparam int unsigned LINE_BYTES       = DEF_LINE_W / 8;
  localparam int unsigned LINES_PER_FRAME  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/trb_line_fifo.sv
// Circular line store with a registered head and the ability to discard the
// unread lines of the frame currently being written.
module trb_line_fifo
  import trb_pkg::*;
#(
  parameter int unsigned W     = DEF_LINE_W + 2,
  parameter int unsigned DEPTH = DEF_NUM_LINE_BUF,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_frame_end,
  input  logic          rd,
  input  logic          flush_frame,
  output logic [CW-1:0] free_cnt,
  output logic [W-1:0]  head_data,
  output logic          head_valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wp_c, wp_next, rp_next;
  logic [CW-1:0] count, cnt_b, cnt_c, cnt_next;
  logic [CW-1:0] fl, fl_b, fl_next;
  logic          rd_eff;

  // fl counts unread lines of the open frame; they are always the newest entries.
  always_comb begin
    rd_eff   = rd && head_valid;
    cnt_b    = count - CW'(rd_eff);
    fl_b     = (rd_eff && fl == count) ? fl - 1'b1 : fl;
    rp_next  = rd_ptr + PW'(rd_eff);
    wp_c     = wr_ptr;
    cnt_c    = cnt_b;
    fl_next  = fl_b;
    if (flush_frame) begin
      wp_c    = wr_ptr - PW'(fl_b);
      cnt_c   = cnt_b - fl_b;
      fl_next = '0;
    end
    wp_next  = wp_c;
    cnt_next = cnt_c;
    if (wr) begin
      wp_next  = wp_c + 1'b1;
      cnt_next = cnt_c + 1'b1;
      fl_next  = wr_frame_end ? '0 : fl_next + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fl         <= '0;
      free_cnt   <= CW'(DEPTH);
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wp_next;
      rd_ptr     <= rp_next;
      count      <= cnt_next;
      fl         <= fl_next;
      free_cnt   <= CW'(DEPTH) - cnt_next;
      head_valid <= cnt_next != '0;
      // Bypass so a line written into an empty store shows up one cycle later.
      if (wr && cnt_c == '0) head_data <= wr_data;
      else if (cnt_next != '0) head_data <= mem[rp_next];
      else head_data <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp_c] <= wr_data;
  end

endmodule

// File: rtl/trb_out_pack.sv
// Packs the decoded turbo byte stream into 512-bit frame-delimited lines for
// the AFU write path, with line buffering and protocol error reporting.
module trb_out_pack
  import trb_pkg::*;
#(
  parameter int unsigned LINE_W       = DEF_LINE_W,
  parameter int unsigned FRAME_BYTES  = LINES_PER_FRAME * LINE_BYTES,
  parameter int unsigned NUM_LINE_BUF = DEF_NUM_LINE_BUF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        st_data_in,
  input  logic              st_valid_in,
  input  logic              st_sop_in,
  input  logic              st_eop_in,
  output logic              st_ready_out,
  output logic [LINE_W-1:0] wr_data,
  output logic              wr_valid,
  output logic              wr_sop,
  output logic              wr_eop,
  input  logic              wr_ready,
  output logic [31:0]       frame_cnt,
  output logic              err_no_sop,
  output logic              err_len,
  output logic              err_ovf
);

  localparam int unsigned LANES = LINE_W / 8;
  localparam int unsigned IW    = $clog2(FRAME_BYTES);
  localparam int unsigned LW    = $clog2(LANES);
  localparam int unsigned CW    = $clog2(NUM_LINE_BUF + 1);

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, idx_eff;
  logic [LW-1:0]       lane_q, lane_d, lane_eff;
  logic [LW+2:0]       lane_bit;
  logic [LINE_W-1:0]   asm_q, asm_d, line_data;
  logic                start, accept, restart, space;
  logic                last_byte, last_lane, end_frame, commit, fifo_wr, first_line;
  logic                err_no_sop_d, err_len_d, err_ovf_d;
  logic [CW-1:0]       free_cnt;
  logic [LINE_W+1:0]   head_data;
  logic                head_valid;

  // Frame sequencing, lane assembly and error detection.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    start      = st_valid_in && st_sop_in;
    accept     = st_valid_in && (start || state_q == FILL);
    restart    = start && state_q == FILL;
    idx_eff    = start ? '0 : idx_q;
    lane_eff   = start ? '0 : lane_q;
    lane_bit   = {lane_eff, 3'b000};
    space      = free_cnt != '0 || (wr_valid && wr_ready);
    last_byte  = idx_eff == IW'(FRAME_BYTES - 1);
    last_lane  = lane_eff == LW'(LANES - 1);
    end_frame  = st_eop_in || last_byte;
    commit     = accept && (last_lane || end_frame);
    fifo_wr    = commit && space;
    first_line = 32'(idx_eff) < LANES;
    // A restart discards the partial line; unwritten lanes stay zero for padding.
    line_data  = start ? '0 : asm_q;
    if (accept && space) line_data[lane_bit +: 8] = st_data_in;
    if (accept) begin
      state_d = end_frame ? IDLE : FILL;
      idx_d   = end_frame ? '0 : idx_eff + 1'b1;
      lane_d  = commit ? '0 : lane_eff + 1'b1;
      asm_d   = commit ? '0 : line_data;
    end
    err_no_sop_d = st_valid_in && !st_sop_in && state_q == IDLE;
    err_len_d    = accept && (restart || (st_eop_in != last_byte));
    err_ovf_d    = err_ovf || (accept && !space);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      lane_q       <= '0;
      asm_q        <= '0;
      err_no_sop   <= 1'b0;
      err_len      <= 1'b0;
      err_ovf      <= 1'b0;
      frame_cnt    <= '0;
      st_ready_out <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      err_no_sop   <= err_no_sop_d;
      err_len      <= err_len_d;
      err_ovf      <= err_ovf_d;
      st_ready_out <= free_cnt >= CW'(2);
      if (wr_valid && wr_ready && wr_eop) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  trb_line_fifo #(
    .W     (LINE_W + 2),
    .DEPTH (NUM_LINE_BUF)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (fifo_wr),
    .wr_data      ({first_line, end_frame, line_data}),
    .wr_frame_end (end_frame),
    .rd           (wr_ready),
    .flush_frame  (restart),
    .free_cnt     (free_cnt),
    .head_data    (head_data),
    .head_valid   (head_valid)
  );

  assign wr_valid = head_valid;
  assign wr_sop   = head_data[LINE_W+1];
  assign wr_eop   = head_data[LINE_W];
  assign wr_data  = head_data[LINE_W-1:0];

endmodule
